// File: rtl/pipeline_exec_ctrl.sv
// Execution controller for the five-stage pipeline: turns debug-unit run/step/stop
// commands and HALT detection into stage enables, drains on HALT, counts active cycles.
module pipeline_exec_ctrl #(
  parameter int NB_CYCLES = 32,
  parameter int N_DRAIN   = 3,
  parameter int NB_STATE  = 3
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 run_cmd_i,
  input  logic                 step_cmd_i,
  input  logic                 stop_cmd_i,
  input  logic                 halt_detected_i,
  input  logic                 load_stall_i,
  output logic                 enable_pc_o,
  output logic                 enable_if_id_o,
  output logic                 enable_pipe_o,
  output logic                 busy_o,
  output logic                 program_end_o,
  output logic [NB_CYCLES-1:0] cycle_count_o,
  output logic [NB_STATE-1:0]  state_o
);

  localparam int NB_DRAIN = (N_DRAIN > 1) ? $clog2(N_DRAIN) : 1;

  // Commands are single-cycle pulses with no handshake: a pulse is either
  // accepted by the current state at the rising edge or silently dropped.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_STEP  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [NB_DRAIN-1:0]  drain_cnt_q, drain_cnt_d;
  logic [NB_CYCLES-1:0] cycle_cnt_q;
  logic                 front_en;

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      if (enable_pipe_o && (cycle_cnt_q != {NB_CYCLES{1'b1}}))
        cycle_cnt_q <= cycle_cnt_q + {{(NB_CYCLES-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    front_en      = 1'b0;
    enable_pipe_o = 1'b0;
    busy_o        = 1'b0;
    program_end_o = 1'b0;
    case (state_q)
      ST_IDLE, ST_PAUSE: begin
        if (run_cmd_i)       state_d = ST_RUN;
        else if (step_cmd_i) state_d = ST_STEP;
      end
      ST_RUN, ST_STEP: begin
        busy_o        = 1'b1;
        enable_pipe_o = 1'b1;
        // HALT in ID freezes fetch in the same cycle it is seen.
        front_en      = !(load_stall_i || halt_detected_i);
        if (halt_detected_i) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = NB_DRAIN'(N_DRAIN - 1);
        end else if (state_q == ST_STEP) begin
          state_d = ST_PAUSE;
        end else if (stop_cmd_i) begin
          state_d = ST_PAUSE;
        end
      end
      ST_DRAIN: begin
        busy_o        = 1'b1;
        enable_pipe_o = 1'b1;
        if (drain_cnt_q == '0) state_d = ST_DONE;
        else                   drain_cnt_d = drain_cnt_q - NB_DRAIN'(1);
      end
      ST_DONE: begin
        program_end_o = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        drain_cnt_d = '0;
      end
    endcase
  end

  assign enable_pc_o    = front_en;
  assign enable_if_id_o = front_en;
  assign cycle_count_o  = cycle_cnt_q;
  assign state_o        = NB_STATE'(state_q);

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Directed bench for pipeline_exec_ctrl: run/stop, stepping, load stall, HALT drain,
// reset abort and cycle-counter saturation (second instance with a 4-bit counter).
module tb_pipeline_exec_ctrl;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        run_cmd_i, step_cmd_i, stop_cmd_i, halt_detected_i, load_stall_i;
  logic        enable_pc_o, enable_if_id_o, enable_pipe_o, busy_o, program_end_o;
  logic [31:0] cycle_count_o;
  logic [2:0]  state_o;
  logic        s_pc, s_ifid, s_pipe, s_busy, s_end;
  logic [3:0]  s_count;
  logic [2:0]  s_state;

  int n_cmp = 0;
  int n_err = 0;
  int hits;

  always #5 clock_i = ~clock_i;

  pipeline_exec_ctrl #(.NB_CYCLES(32), .N_DRAIN(3), .NB_STATE(3)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .run_cmd_i(run_cmd_i), .step_cmd_i(step_cmd_i), .stop_cmd_i(stop_cmd_i),
    .halt_detected_i(halt_detected_i), .load_stall_i(load_stall_i),
    .enable_pc_o(enable_pc_o), .enable_if_id_o(enable_if_id_o),
    .enable_pipe_o(enable_pipe_o), .busy_o(busy_o), .program_end_o(program_end_o),
    .cycle_count_o(cycle_count_o), .state_o(state_o)
  );

  pipeline_exec_ctrl #(.NB_CYCLES(4), .N_DRAIN(3), .NB_STATE(3)) dut_sat (
    .clock_i(clock_i), .reset_i(reset_i),
    .run_cmd_i(run_cmd_i), .step_cmd_i(step_cmd_i), .stop_cmd_i(stop_cmd_i),
    .halt_detected_i(halt_detected_i), .load_stall_i(load_stall_i),
    .enable_pc_o(s_pc), .enable_if_id_o(s_ifid),
    .enable_pipe_o(s_pipe), .busy_o(s_busy), .program_end_o(s_end),
    .cycle_count_o(s_count), .state_o(s_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic pc, input logic ifid,
                            input logic pipe, input logic [2:0] st);
    check_eq({tag, ".pc"},    enable_pc_o,    pc);
    check_eq({tag, ".if_id"}, enable_if_id_o, ifid);
    check_eq({tag, ".pipe"},  enable_pipe_o,  pipe);
    check_eq({tag, ".state"}, state_o,        st);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic probe();
    @(negedge clock_i);
  endtask

  initial begin
    reset_i = 1'b0; run_cmd_i = 1'b0; step_cmd_i = 1'b0; stop_cmd_i = 1'b0;
    halt_detected_i = 1'b0; load_stall_i = 1'b0;
    tick(); tick();
    reset_i = 1'b1;
    probe();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 3'd0);
    check_eq("reset.busy", busy_o, 0);
    check_eq("reset.end", program_end_o, 0);
    check_eq("reset.count", cycle_count_o, 0);
    check_eq("reset.sat_count", s_count, 0);

    // Run for exactly 10 enabled cycles; stop sampled at the 10th edge.
    run_cmd_i = 1'b1; tick(); run_cmd_i = 1'b0;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) stop_cmd_i = 1'b1;
      probe();
      if (enable_pipe_o) hits++;
      tick();
      stop_cmd_i = 1'b0;
    end
    probe();
    check_eq("run.pipe_cycles", hits, 10);
    check_outs("paused", 1'b0, 1'b0, 1'b0, 3'd2);
    check_eq("run.count", cycle_count_o, 10);

    // Three single steps, five cycles apart.
    for (int k = 0; k < 3; k++) begin
      step_cmd_i = 1'b1; tick(); step_cmd_i = 1'b0;
      probe();
      check_outs("step", 1'b1, 1'b1, 1'b1, 3'd3);
      tick();
      probe();
      check_outs("step_back", 1'b0, 1'b0, 1'b0, 3'd2);
      repeat (3) tick();
    end
    check_eq("step.count", cycle_count_o, 13);

    // Load-use stall for one RUN cycle.
    run_cmd_i = 1'b1; tick(); run_cmd_i = 1'b0;
    load_stall_i = 1'b1;
    probe();
    check_outs("stall", 1'b0, 1'b0, 1'b1, 3'd1);
    tick();
    load_stall_i = 1'b0;
    probe();
    check_outs("after_stall", 1'b1, 1'b1, 1'b1, 3'd1);
    tick();
    check_eq("stall.count", cycle_count_o, 15);

    // Halt together with stop in RUN: halt wins, drain 3 cycles, then DONE.
    halt_detected_i = 1'b1; stop_cmd_i = 1'b1;
    probe();
    check_outs("halt", 1'b0, 1'b0, 1'b1, 3'd1);
    tick();
    halt_detected_i = 1'b0; stop_cmd_i = 1'b0;
    for (int d = 0; d < 3; d++) begin
      probe();
      check_outs("drain", 1'b0, 1'b0, 1'b1, 3'd4);
      check_eq("drain.busy", busy_o, 1);
      check_eq("drain.end", program_end_o, 0);
      tick();
    end
    probe();
    check_outs("done", 1'b0, 1'b0, 1'b0, 3'd5);
    check_eq("done.end", program_end_o, 1);
    check_eq("done.busy", busy_o, 0);
    check_eq("done.count", cycle_count_o, 19);
    run_cmd_i = 1'b1; tick(); run_cmd_i = 1'b0;
    probe();
    check_eq("done_run.state", state_o, 5);
    check_eq("done_run.count", cycle_count_o, 19);

    // Halt seen during a STEP still drains fully.
    reset_i = 1'b0; tick(); reset_i = 1'b1;
    probe();
    check_eq("reset2.state", state_o, 0);
    check_eq("reset2.count", cycle_count_o, 0);
    step_cmd_i = 1'b1; tick();
    halt_detected_i = 1'b1;
    probe();
    check_outs("step_halt", 1'b0, 1'b0, 1'b1, 3'd3);
    tick();
    halt_detected_i = 1'b0; step_cmd_i = 1'b0;
    for (int d = 0; d < 3; d++) begin
      probe();
      check_outs("step_drain", 1'b0, 1'b0, 1'b1, 3'd4);
      tick();
    end
    probe();
    check_eq("step_done.state", state_o, 5);
    check_eq("step_done.end", program_end_o, 1);
    check_eq("step_done.count", cycle_count_o, 4);

    // Reset in the second DRAIN cycle aborts the drain.
    reset_i = 1'b0; tick(); reset_i = 1'b1;
    run_cmd_i = 1'b1; tick(); run_cmd_i = 1'b0;
    halt_detected_i = 1'b1; tick(); halt_detected_i = 1'b0;
    tick();
    reset_i = 1'b0;
    probe();
    check_eq("abort.pre_state", state_o, 4);
    tick();
    reset_i = 1'b1;
    probe();
    check_outs("abort", 1'b0, 1'b0, 1'b0, 3'd0);
    check_eq("abort.count", cycle_count_o, 0);
    check_eq("abort.busy", busy_o, 0);
    check_eq("abort.end", program_end_o, 0);
    check_eq("abort.sat_count", s_count, 0);

    // 20 run cycles: 32-bit counter reads 20, 4-bit counter saturates at 15.
    run_cmd_i = 1'b1; tick(); run_cmd_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 19) stop_cmd_i = 1'b1;
      tick();
      stop_cmd_i = 1'b0;
    end
    probe();
    check_eq("sat.count_wide", cycle_count_o, 20);
    check_eq("sat.count_narrow", s_count, 15);
    check_eq("sat.state", state_o, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
